// File: rtl/audio_mix_tdm.sv
`default_nettype none
// ============================================================================
//  Module   : audio_mix_tdm
//  Purpose  : N-channel shift-and-add audio mixer sharing one adder over time,
//             with mute, saturation, sticky clip and overrun flags.
//  Revision : 1.0
// ============================================================================
module audio_mix_tdm #(
    parameter int CHANNELS  = 3,
    parameter int IN_W      = 8,
    parameter int GAIN_W    = 3,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 5,
    parameter int SIGNED    = 0
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       ce_sample,
    input  logic [CHANNELS*IN_W-1:0]   ch_data,
    input  logic [CHANNELS*GAIN_W-1:0] ch_gain,
    input  logic [CHANNELS-1:0]        ch_mute,
    input  logic                       clip_clr,
    output logic [OUT_W-1:0]           out_sample,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       clip,
    output logic                       overrun
);

    localparam int ACC_W = IN_W + (2**GAIN_W - 1) + $clog2(CHANNELS) + 1;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int S_W   = ((ACC_W + OUT_SHIFT > OUT_W) ? ACC_W + OUT_SHIFT : OUT_W) + 1;

    localparam logic [IDX_W-1:0]     c_LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic signed [S_W-1:0] c_U_MAX   = {{(S_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic signed [S_W-1:0] c_S_MAX   = {{(S_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] c_S_MIN   = {{(S_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                       state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [ACC_W-1:0]             acc_q;
    logic [CHANNELS*IN_W-1:0]     data_q;
    logic [CHANNELS*GAIN_W-1:0]   gain_q;
    logic [CHANNELS-1:0]          mute_q;
    logic [OUT_W-1:0]             out_sample_q;
    logic                         out_valid_q;
    logic                         busy_q;
    logic                         clip_q;
    logic                         overrun_q;

    logic [IN_W-1:0]              w_data [CHANNELS];
    logic [GAIN_W-1:0]            w_gain [CHANNELS];
    logic                         w_sx;
    logic [ACC_W-1:0]             w_ext;
    logic [ACC_W-1:0]             w_term;
    logic [ACC_W-1:0]             acc_d;
    logic signed [S_W-1:0]        w_s;
    logic [OUT_W-1:0]             sat_d;
    logic                         clip_evt;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
            assign w_data[k] = data_q[k*IN_W +: IN_W];
            assign w_gain[k] = gain_q[k*GAIN_W +: GAIN_W];
        end
    endgenerate

    // Guard bits make the running sum exact, so no wrap can occur here.
    assign w_sx   = (SIGNED != 0) && w_data[idx_q][IN_W-1];
    assign w_ext  = {{(ACC_W-IN_W){w_sx}}, w_data[idx_q]};
    assign w_term = mute_q[idx_q] ? '0 : (w_ext << w_gain[idx_q]);
    assign acc_d  = acc_q + w_term;
    assign w_s    = $signed({{(S_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}) <<< OUT_SHIFT;

    always_comb begin
        sat_d    = w_s[OUT_W-1:0];
        clip_evt = 1'b0;
        if (SIGNED != 0) begin
            if (w_s > c_S_MAX) begin
                sat_d    = {1'b0, {(OUT_W-1){1'b1}}};
                clip_evt = 1'b1;
            end else if (w_s < c_S_MIN) begin
                sat_d    = {1'b1, {(OUT_W-1){1'b0}}};
                clip_evt = 1'b1;
            end
        end else if (w_s > c_U_MAX) begin
            sat_d    = '1;
            clip_evt = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            data_q       <= '0;
            gain_q       <= '0;
            mute_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ce_sample) begin
                        data_q  <= ch_data;
                        gain_q  <= ch_gain;
                        mute_q  <= ch_mute;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc_q <= acc_d;
                    if (idx_q == c_LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= S_OUT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_OUT: begin
                    out_sample_q <= sat_d;
                    out_valid_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
            // A set event in the same cycle as clip_clr keeps the flag high.
            clip_q    <= ((state_q == S_OUT) && clip_evt) || (clip_q && !clip_clr);
            overrun_q <= (ce_sample && (state_q != S_IDLE)) || (overrun_q && !clip_clr);
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign clip       = clip_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire
